// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: serializer phases, default oversampling and frame timing.
// Kept generic so the receive path can import the same package.
package rs232_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Cycles a frame occupies on the line (start + data + stop bits).
    function automatic int frame_cycles(input int data_bits, input int stop_bits, input int oversample);
        return (1 + data_bits + stop_bits) * oversample;
    endfunction

endpackage

// File: rtl/rs232_txd_shift.sv
// Frame serializer: load/shift register, sample and bit counters, registered Txd.
// Done flags the final cycle of the current phase so the arbiter FSM can advance.
module rs232_txd_shift
    import rs232_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clock16x,
    input  logic                 Reset,
    input  logic [1:0]           State,
    input  logic                 Load,
    input  logic [DATA_BITS-1:0] LoadData,
    output logic                 Txd,
    output logic                 Done
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
    logic                 last_data;

    assign bit_end   = (sample_cnt == SW'(OVERSAMPLE - 1));
    assign last_data = (bit_cnt == BW'(DATA_BITS - 1));

    always_comb begin
        Done = 1'b0;
        if (bit_end) begin
            case (State)
                START:   Done = 1'b1;
                DATA:    Done = last_data;
                STOP:    Done = (bit_cnt == BW'(STOP_BITS - 1));
                default: Done = 1'b0;
            endcase
        end
    end

    // Txd always carries the level of the bit being timed by sample_cnt; the next
    // level is registered on the last sample of the current bit.
    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            Txd        <= 1'b1;
        end else if (Load) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shreg      <= LoadData;
            Txd        <= 1'b0;
        end else if (State == IDLE) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            Txd        <= 1'b1;
        end else begin
            sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;
            if (bit_end) begin
                bit_cnt <= Done ? '0 : bit_cnt + 1'b1;
                case (State)
                    START: Txd <= shreg[0];
                    DATA: begin
                        shreg <= shreg >> 1;
                        Txd   <= last_data ? 1'b1 : shreg[1];
                    end
                    default: Txd <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Two-requester round-robin front end for one RS232 transmit serializer.
// The grant is held for a whole frame; Busy and GrantId report the current owner.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clock16x,
    input  logic                 Reset,
    input  logic                 Req0Valid,
    input  logic [DATA_BITS-1:0] Req0Data,
    output logic                 Req0Ready,
    input  logic                 Req1Valid,
    input  logic [DATA_BITS-1:0] Req1Data,
    output logic                 Req1Ready,
    output logic                 Txd,
    output logic                 Busy,
    output logic                 GrantId
);

    tx_state_t            state;
    tx_state_t            state_next;
    logic                 last_grant;
    logic                 sel0;
    logic                 sel1;
    logic                 accept;
    logic                 phase_done;
    logic [DATA_BITS-1:0] load_data;

    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (phase_done) state_next = DATA;
            DATA:    if (phase_done) state_next = STOP;
            STOP:    if (phase_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Under contention the requester that did not own the last frame wins.
    always_comb begin
        sel0      = Req0Valid && (!Req1Valid || last_grant);
        sel1      = Req1Valid && (!Req0Valid || !last_grant);
        Req0Ready = (state == IDLE) && !Reset && sel0;
        Req1Ready = (state == IDLE) && !Reset && sel1;
        accept    = Req0Ready || Req1Ready;
        load_data = Req1Ready ? Req1Data : Req0Data;
    end

    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            Busy       <= 1'b0;
            GrantId    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            Busy       <= 1'b1;
            GrantId    <= Req1Ready;
            last_grant <= Req1Ready;
        end else if (state == STOP && phase_done) begin
            Busy       <= 1'b0;
        end
    end

    rs232_txd_shift #(
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) u_shift (
        .Clock16x(Clock16x),
        .Reset   (Reset),
        .State   (state),
        .Load    (accept),
        .LoadData(load_data),
        .Txd     (Txd),
        .Done    (phase_done)
    );

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: cycle-level reference model plus a line-decoding
// scoreboard monitor, with a second instance for the 7-data/2-stop framing.
module tb_rs232_tx_arbiter;

    localparam int OS    = 16;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int FRAME = (1 + DB + SB) * OS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, v0, v1;
    logic [7:0] d0, d1;
    logic       r0, r1, txd, busy, gid;

    rs232_tx_arbiter dut (
        .Clock16x (clk),
        .Reset    (rst),
        .Req0Valid(v0),
        .Req0Data (d0),
        .Req0Ready(r0),
        .Req1Valid(v1),
        .Req1Data (d1),
        .Req1Ready(r1),
        .Txd      (txd),
        .Busy     (busy),
        .GrantId  (gid)
    );

    logic       rst2, v0b, v1b;
    logic [6:0] d0b, d1b;
    logic       r0b, r1b, txdb, busyb, gidb;

    rs232_tx_arbiter #(.OVERSAMPLE(16), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
        .Clock16x (clk),
        .Reset    (rst2),
        .Req0Valid(v0b),
        .Req0Data (d0b),
        .Req0Ready(r0b),
        .Req1Valid(v1b),
        .Req1Data (d1b),
        .Req1Ready(r1b),
        .Txd      (txdb),
        .Busy     (busyb),
        .GrantId  (gidb)
    );

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } frame_t;

    frame_t sb_q[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;

    // Reference model: cycles left in the current frame, round-robin history, owner.
    int         m_left = 0;
    logic       m_last = 1'b1;
    logic       m_gid  = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic irst, input logic iv0, input logic [7:0] id0,
                         input logic iv1, input logic [7:0] id1,
                         output logic acc0, output logic acc1);
        logic e0, e1, etx;
        int   b;
        @(negedge clk);
        rst = irst; v0 = iv0; d0 = id0; v1 = iv1; d1 = id1;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!irst && m_left == 0) begin
            if (iv0 && (!iv1 || m_last)) e0 = 1'b1;
            else if (iv1)                e1 = 1'b1;
        end
        etx = 1'b1;
        if (m_left > 0) begin
            b = (FRAME - m_left) / OS;
            if (b == 0)       etx = 1'b0;
            else if (b <= DB) etx = m_data[b-1];
        end
        check("ready0", 32'(r0), 32'(e0));
        check("ready1", 32'(r1), 32'(e1));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("grant_id", 32'(gid), 32'(m_gid));
        check("txd", 32'(txd), 32'(etx));
        acc0 = e0;
        acc1 = e1;
        cyc++;
        if (irst) begin
            m_left = 0;
            m_last = 1'b1;
            m_gid  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (e0 || e1) begin
            m_left = FRAME;
            m_last = e1;
            m_gid  = e1;
            m_data = e1 ? id1 : id0;
            sb_q.push_back('{id: e1, data: m_data});
        end
    endtask

    task automatic idle(input int n);
        logic a0, a1;
        repeat (n) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, a0, a1);
    endtask

    // Holds each wanted request valid until the model says it is accepted.
    task automatic xfer(input logic w0, input logic [7:0] x0, input logic w1, input logic [7:0] x1,
                        output int acc_cyc);
        logic p0, p1, a0, a1;
        int   budget;
        p0 = w0; p1 = w1; budget = 3 * FRAME; acc_cyc = -1;
        while ((p0 || p1) && budget > 0) begin
            cycle(1'b0, p0, x0, p1, x1, a0, a1);
            if (a0) p0 = 1'b0;
            if (a1) p1 = 1'b0;
            if (a0 || a1) acc_cyc = cyc;
            budget--;
        end
        if (p0 || p1) begin
            fails++;
            $display("FAIL xfer_timeout: pending=%0b%0b, expected accept within %0d cycles", p1, p0, 3 * FRAME);
        end
    endtask

    // Monitor: decodes Txd at mid-bit and checks each frame against the scoreboard.
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic       mon_gid    = 1'b0;
    frame_t     mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!mon_active && txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_frame: got start bit, expected idle line (t=%0t)", $time);
                    mon_exp = '1;
                end else begin
                    mon_exp = sb_q.pop_front();
                end
            end
            if (rst) mon_active = 1'b0;
            if (mon_active) begin
                if (mon_cnt == OS / 2) begin
                    check("start_bit", 32'(txd), 32'd0);
                    mon_gid = gid;
                end
                if (mon_cnt >= OS / 2 + OS && mon_cnt <= OS / 2 + DB * OS && (mon_cnt - OS / 2) % OS == 0)
                    mon_byte[(mon_cnt - OS / 2) / OS - 1] = txd;
                if (mon_cnt == OS / 2 + (DB + 1) * OS) begin
                    check("stop_bit", 32'(txd), 32'd1);
                    check("rx_byte", 32'(mon_byte), 32'(mon_exp.data));
                    check("rx_grant", 32'(mon_gid), 32'(mon_exp.id));
                    mon_active = 1'b0;
                end
                mon_cnt++;
            end
        end
    end

    initial begin
        logic       a0, a1, rv0, rv1, rrst, e7;
        logic [7:0] rd0, rd1;
        logic [6:0] byte7;
        int         c1, c2, c3;

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        rst2 = 1'b1; v0b = 1'b0; v1b = 1'b0; d0b = 7'h00; d1b = 7'h00;
        repeat (2) @(negedge clk);
        // Reset wins over valid requests.
        repeat (2) cycle(1'b1, 1'b1, 8'hAA, 1'b1, 8'h55, a0, a1);

        // 7 data bits, 2 stop bits on the second instance.
        byte7 = 7'h41;
        @(negedge clk);
        rst2 = 1'b0; v0b = 1'b1; d0b = byte7;
        #1;
        check("b7_ready", 32'(r0b), 32'd1);
        for (int i = 0; i < (1 + 7 + 2) * 16; i++) begin
            @(negedge clk);
            v0b = 1'b0;
            #1;
            if (i < 16)       e7 = 1'b0;
            else if (i < 128) e7 = byte7[i/16 - 1];
            else              e7 = 1'b1;
            check("b7_txd", 32'(txdb), 32'(e7));
            check("b7_busy", 32'(busyb), 32'd1);
        end
        @(negedge clk);
        #1;
        check("b7_busy_end", 32'(busyb), 32'd0);
        check("b7_txd_idle", 32'(txdb), 32'd1);

        // Single request from requester 0.
        xfer(1'b1, 8'h55, 1'b0, 8'h00, c1);
        idle(FRAME + 4);

        // Contention: alternation over four frames.
        xfer(1'b1, 8'hA5, 1'b1, 8'h3C, c1);
        xfer(1'b1, 8'h96, 1'b1, 8'h69, c1);
        idle(FRAME + 4);

        // Requester 1 alone, back to back.
        xfer(1'b0, 8'h00, 1'b1, 8'h01, c1);
        xfer(1'b0, 8'h00, 1'b1, 8'h80, c2);
        xfer(1'b0, 8'h00, 1'b1, 8'hFF, c3);
        check("period_1", 32'(c2 - c1), 32'(FRAME + 1));
        check("period_2", 32'(c3 - c2), 32'(FRAME + 1));
        idle(FRAME + 4);

        // Reset during data bit 3, then a clean frame.
        xfer(1'b1, 8'hC3, 1'b0, 8'h00, c1);
        idle(70);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, a0, a1);
        xfer(1'b1, 8'h0F, 1'b0, 8'h00, c1);
        idle(FRAME + 4);

        // Short valid pulse while busy is ignored.
        xfer(1'b1, 8'h5A, 1'b0, 8'h00, c1);
        idle(20);
        cycle(1'b0, 1'b1, 8'hE7, 1'b0, 8'h00, a0, a1);
        idle(FRAME + 4);

        // Randomized traffic with data churn, withdrawals and rare resets.
        rv0 = 1'b0; rv1 = 1'b0; rd0 = 8'h00; rd1 = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rv0 = ~rv0;
            if ($urandom_range(0, 7) == 0) rv1 = ~rv1;
            if ($urandom_range(0, 3) == 0) rd0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd1 = 8'($urandom);
            rrst = ($urandom_range(0, 999) == 0);
            cycle(rrst, rv0, rd0, rv1, rd1, a0, a1);
        end
        idle(FRAME + 10);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
